// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request, register-file write and scoreboard signals for regfile_wb_arbiter
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              RegWrite_control;
    logic [ADDR_W-1:0] Write_reg;
    logic [DATA_W-1:0] Write_data;
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_reg;
    logic [ADDR_W-1:0] chk_reg1;
    logic [ADDR_W-1:0] chk_reg2;
    logic              busy1;
    logic              busy2;

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output rsv_valid, rsv_reg, chk_reg1, chk_reg2,
        input  a_ready, b_ready, RegWrite_control, Write_reg, Write_data, busy1, busy2
    );

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  rsv_valid, rsv_reg, chk_reg1, chk_reg2,
        output a_ready, b_ready, RegWrite_control, Write_reg, Write_data, busy1, busy2
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter for the register file write port; REGFILE_WB_SCOREBOARD_EN adds the busy scoreboard
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic clk,
    input logic reset,
    regfile_wb_arbiter_if.slave bus
);
    logic              prio;
    logic              a_grant;
    logic              b_grant;
    logic              grant;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        a_grant  = reset && bus.a_valid && (!bus.b_valid || !prio);
        b_grant  = reset && bus.b_valid && (!bus.a_valid || prio);
        grant    = a_grant || b_grant;
        sel_reg  = a_grant ? bus.a_reg : bus.b_reg;
        sel_data = a_grant ? bus.a_data : bus.b_data;
    end

    assign bus.a_ready = a_grant;
    assign bus.b_ready = b_grant;

    // prio points at the loser so contending requesters alternate
    always_ff @(posedge clk) begin
        if (!reset) begin
            prio                 <= 1'b0;
            bus.RegWrite_control <= 1'b0;
            bus.Write_reg        <= '0;
            bus.Write_data       <= '0;
        end else begin
            bus.RegWrite_control <= grant && (sel_reg != '0);
            if (grant) begin
                prio           <= a_grant;
                bus.Write_reg  <= sel_reg;
                bus.Write_data <= sel_data;
            end
        end
    end

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [2**ADDR_W-1:0] busy;

    // set is written last so it wins over a same-edge clear; bit 0 is never set
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            if (bus.RegWrite_control) busy[bus.Write_reg] <= 1'b0;
            if (bus.rsv_valid && bus.rsv_reg != '0) busy[bus.rsv_reg] <= 1'b1;
        end
    end

    assign bus.busy1 = busy[bus.chk_reg1];
    assign bus.busy2 = busy[bus.chk_reg2];
`else
    assign bus.busy1 = 1'b0;
    assign bus.busy2 = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector table plus reserve/commit and reset sequences for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  br;
        logic [31:0] bd;
        logic        e_ardy;
        logic        e_brdy;
        logic        e_we;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[11];

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd);
        bus.a_valid = av;
        bus.a_reg   = ar;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_reg   = br;
        bus.b_data  = bd;
    endtask

    task automatic edge_tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // prio starts at A; the lone B write at 2 re-points it at A before the contention run
        vecs[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  32'h0,   1, 0, 1, 5,  32'hDEADBEEF};
        vecs[1]  = '{0, 0,  32'h0,        0, 0,  32'h0,   0, 0, 0, 5,  32'hDEADBEEF};
        vecs[2]  = '{0, 0,  32'h0,        1, 9,  32'h99,  0, 1, 1, 9,  32'h99};
        vecs[3]  = '{1, 1,  32'h101,      1, 11, 32'h111, 1, 0, 1, 1,  32'h101};
        vecs[4]  = '{1, 2,  32'h102,      1, 11, 32'h111, 0, 1, 1, 11, 32'h111};
        vecs[5]  = '{1, 2,  32'h102,      1, 12, 32'h112, 1, 0, 1, 2,  32'h102};
        vecs[6]  = '{1, 3,  32'h103,      1, 12, 32'h112, 0, 1, 1, 12, 32'h112};
        vecs[7]  = '{0, 0,  32'h0,        1, 0,  32'h1234, 0, 1, 0, 0, 32'h1234};
        vecs[8]  = '{0, 0,  32'h0,        0, 0,  32'h0,   0, 0, 0, 0,  32'h1234};
        vecs[9]  = '{1, 31, 32'hFFFFFFFF, 0, 0,  32'h0,   1, 0, 1, 31, 32'hFFFFFFFF};
        vecs[10] = '{1, 4,  32'h104,      1, 13, 32'h113, 0, 1, 1, 13, 32'h113};

        reset = 1'b0;
        drive(1, 3, 32'h33, 1, 4, 32'h44);
        bus.rsv_valid = 1'b1;
        bus.rsv_reg   = 5'd6;
        bus.chk_reg1  = 5'd6;
        bus.chk_reg2  = 5'd0;
        edge_tick();
        edge_tick();
        chk("rst_a_ready", {31'b0, bus.a_ready}, 0);
        chk("rst_b_ready", {31'b0, bus.b_ready}, 0);
        chk("rst_we", {31'b0, bus.RegWrite_control}, 0);
        chk("rst_wreg", {27'b0, bus.Write_reg}, 0);
        chk("rst_wdata", bus.Write_data, 0);
        chk("rst_busy1", {31'b0, bus.busy1}, 0);
        chk("rst_busy2", {31'b0, bus.busy2}, 0);
        bus.rsv_valid = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        edge_tick();

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd);
            @(negedge clk);
            chk($sformatf("v%0d_a_ready", i), {31'b0, bus.a_ready}, {31'b0, vecs[i].e_ardy});
            chk($sformatf("v%0d_b_ready", i), {31'b0, bus.b_ready}, {31'b0, vecs[i].e_brdy});
            edge_tick();
            chk($sformatf("v%0d_we", i), {31'b0, bus.RegWrite_control}, {31'b0, vecs[i].e_we});
            chk($sformatf("v%0d_wreg", i), {27'b0, bus.Write_reg}, {27'b0, vecs[i].e_wreg});
            chk($sformatf("v%0d_wdata", i), bus.Write_data, vecs[i].e_wdata);
        end
        drive(0, 0, 0, 0, 0, 0);
        edge_tick();
        chk("idle_we", {31'b0, bus.RegWrite_control}, 0);

        // reserve reg 7, then commit a write to it
        bus.rsv_valid = 1'b1;
        bus.rsv_reg   = 5'd7;
        bus.chk_reg1  = 5'd7;
        bus.chk_reg2  = 5'd0;
        @(negedge clk);
        chk("sb_pre_busy1", {31'b0, bus.busy1}, 0);
        edge_tick();
        bus.rsv_valid = 1'b0;
        chk("sb_rsv_busy1", {31'b0, bus.busy1}, {31'b0, SB});
        chk("sb_q0_busy2", {31'b0, bus.busy2}, 0);
        drive(1, 7, 32'h77, 0, 0, 0);
        @(negedge clk);
        chk("sb_a_ready", {31'b0, bus.a_ready}, 1);
        edge_tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("sb_strobe_we", {31'b0, bus.RegWrite_control}, 1);
        chk("sb_strobe_busy1", {31'b0, bus.busy1}, {31'b0, SB});
        edge_tick();
        chk("sb_commit_busy1", {31'b0, bus.busy1}, 0);
        chk("sb_commit_we", {31'b0, bus.RegWrite_control}, 0);

        // re-reserve reg 7 on the same edge its commit lands: set wins
        drive(1, 7, 32'h78, 0, 0, 0);
        edge_tick();
        drive(0, 0, 0, 0, 0, 0);
        bus.rsv_valid = 1'b1;
        bus.rsv_reg   = 5'd7;
        chk("sim_strobe_we", {31'b0, bus.RegWrite_control}, 1);
        edge_tick();
        bus.rsv_valid = 1'b0;
        chk("sim_busy1", {31'b0, bus.busy1}, {31'b0, SB});
        chk("sim_we", {31'b0, bus.RegWrite_control}, 0);

        // reset while a write sits in the stage drops it and clears busy
        bus.rsv_valid = 1'b1;
        bus.rsv_reg   = 5'd8;
        bus.chk_reg2  = 5'd8;
        drive(1, 8, 32'h88, 0, 0, 0);
        edge_tick();
        bus.rsv_valid = 1'b0;
        chk("mid_busy2", {31'b0, bus.busy2}, {31'b0, SB});
        chk("mid_we", {31'b0, bus.RegWrite_control}, 1);
        drive(1, 9, 32'h90, 1, 10, 32'hA0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_a_ready", {31'b0, bus.a_ready}, 0);
        chk("mid_rst_b_ready", {31'b0, bus.b_ready}, 0);
        edge_tick();
        chk("mid_rst_we", {31'b0, bus.RegWrite_control}, 0);
        chk("mid_rst_wreg", {27'b0, bus.Write_reg}, 0);
        chk("mid_rst_wdata", bus.Write_data, 0);
        chk("mid_rst_busy1", {31'b0, bus.busy1}, 0);
        chk("mid_rst_busy2", {31'b0, bus.busy2}, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_a_ready", {31'b0, bus.a_ready}, 1);
        chk("post_rst_b_ready", {31'b0, bus.b_ready}, 0);
        edge_tick();
        chk("post_rst_wreg", {27'b0, bus.Write_reg}, 9);
        drive(0, 0, 0, 0, 0, 0);
        edge_tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
